// File: rtl/tqvp_bus_initiator.sv
// Host-side driver for the TinyQV peripheral bus. Commands are buffered in a
// two-entry queue, issued one at a time as data_write_n / data_read_n cycles
// toward a single responder, and answered in order with one response each.
module tqvp_bus_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255  // read wait limit, 0 = unbounded
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        rsp_error,
    output logic        busy,
    output logic [5:0]  per_address,
    output logic [31:0] per_wdata,
    output logic [1:0]  per_write_n,
    output logic [1:0]  per_read_n,
    input  logic [31:0] per_rdata,
    input  logic        per_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    localparam logic [1:0]  BUS_IDLE    = 2'b11;
    localparam logic [1:0]  SIZE_BAD    = 2'b11;
    localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam bit          TMO_ENABLED = (TIMEOUT_CYCLES != 0);

    // Read data is zero-extended above the transfer size.
    function automatic logic [31:0] f_mask(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   f_mask = {24'h0, data[7:0]};
            2'b01:   f_mask = {16'h0, data[15:0]};
            default: f_mask = data;
        endcase
    endfunction

    // Command queue
    cmd_t        r_q [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        w_push;
    logic        w_pop;
    cmd_t        w_head;

    // FSM and registered bus/response state
    state_t      r_state,       w_state_nxt;
    cmd_t        r_active,      w_active_nxt;
    logic        r_issued,      w_issued_nxt;
    logic [31:0] r_tmo_cnt,     w_tmo_cnt_nxt;
    logic [5:0]  r_per_address, w_per_address_nxt;
    logic [31:0] r_per_wdata,   w_per_wdata_nxt;
    logic [1:0]  r_per_write_n, w_per_write_n_nxt;
    logic [1:0]  r_per_read_n,  w_per_read_n_nxt;
    logic        r_rsp_valid,   w_rsp_valid_nxt;
    logic        r_rsp_write,   w_rsp_write_nxt;
    logic [31:0] r_rsp_rdata,   w_rsp_rdata_nxt;
    logic        r_rsp_timeout, w_rsp_timeout_nxt;
    logic        r_rsp_error,   w_rsp_error_nxt;

    // Ready comes from the registered count only, so a full queue never
    // accepts even when the FSM pops in the same cycle.
    assign cmd_ready = (r_count != 2'd2);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_head    = r_q[r_rd_ptr];

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others.
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Queue storage.
    always_ff @(posedge clk) begin
        // NOTE: payload entries need no reset; the count guards every read.
        if (w_push) r_q[r_wr_ptr] <= '{write: cmd_write, size: cmd_size,
                                       addr: cmd_addr, wdata: cmd_wdata};
    end

    // Next-state and next-output logic for the bus sequencer.
    always_comb begin
        // NOTE: every output starts from its held value so no path infers a latch.
        w_state_nxt       = r_state;
        w_active_nxt      = r_active;
        w_issued_nxt      = r_issued;
        w_tmo_cnt_nxt     = r_tmo_cnt;
        w_per_address_nxt = r_per_address;
        w_per_wdata_nxt   = r_per_wdata;
        w_per_write_n_nxt = r_per_write_n;
        w_per_read_n_nxt  = r_per_read_n;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_write_nxt   = r_rsp_write;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_rsp_error_nxt   = r_rsp_error;
        w_pop             = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_count != 2'd0) begin
                    w_pop         = 1'b1;
                    w_active_nxt  = w_head;
                    w_issued_nxt  = 1'b0;
                    w_tmo_cnt_nxt = 32'd0;
                    if (w_head.size == SIZE_BAD) begin
                        // Illegal size is answered directly without touching the bus.
                        w_state_nxt       = S_RESP;
                        w_rsp_valid_nxt   = 1'b1;
                        w_rsp_write_nxt   = w_head.write;
                        w_rsp_rdata_nxt   = 32'd0;
                        w_rsp_timeout_nxt = 1'b0;
                        w_rsp_error_nxt   = 1'b1;
                    end else if (w_head.write) begin
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_state_nxt = S_READ;
                    end
                end
            end

            S_WRITE: begin
                if (!r_issued) begin
                    w_issued_nxt      = 1'b1;
                    w_per_address_nxt = r_active.addr;
                    w_per_wdata_nxt   = r_active.wdata;
                    w_per_write_n_nxt = r_active.size;
                end else begin
                    w_per_write_n_nxt = BUS_IDLE;
                    w_state_nxt       = S_RESP;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_write_nxt   = r_active.write;
                    w_rsp_rdata_nxt   = 32'd0;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_error_nxt   = 1'b0;
                end
            end

            S_READ: begin
                if (!r_issued) begin
                    w_issued_nxt      = 1'b1;
                    w_per_address_nxt = r_active.addr;
                    w_per_read_n_nxt  = r_active.size;
                end else if (per_ready) begin
                    w_per_read_n_nxt  = BUS_IDLE;
                    w_state_nxt       = S_RESP;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_write_nxt   = 1'b0;
                    w_rsp_rdata_nxt   = f_mask(r_active.size, per_rdata);
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_error_nxt   = 1'b0;
                end else if (TMO_ENABLED && (r_tmo_cnt == TMO_LAST)) begin
                    w_per_read_n_nxt  = BUS_IDLE;
                    w_state_nxt       = S_RESP;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_write_nxt   = 1'b0;
                    w_rsp_rdata_nxt   = 32'hFFFF_FFFF;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_error_nxt   = 1'b0;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 32'd1;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sequencer state register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_active      <= '0;
            r_issued      <= 1'b0;
            r_tmo_cnt     <= 32'd0;
            r_per_address <= 6'd0;
            r_per_wdata   <= 32'd0;
            r_per_write_n <= BUS_IDLE;
            r_per_read_n  <= BUS_IDLE;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_timeout <= 1'b0;
            r_rsp_error   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_active      <= w_active_nxt;
            r_issued      <= w_issued_nxt;
            r_tmo_cnt     <= w_tmo_cnt_nxt;
            r_per_address <= w_per_address_nxt;
            r_per_wdata   <= w_per_wdata_nxt;
            r_per_write_n <= w_per_write_n_nxt;
            r_per_read_n  <= w_per_read_n_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_write   <= w_rsp_write_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_rsp_error   <= w_rsp_error_nxt;
        end
    end

    assign per_address = r_per_address;
    assign per_wdata   = r_per_wdata;
    assign per_write_n = r_per_write_n;
    assign per_read_n  = r_per_read_n;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_write   = r_rsp_write;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;
    assign rsp_error   = r_rsp_error;
    assign busy        = (r_state != S_IDLE) || (r_count != 2'd0);

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Self-checking bench for tqvp_bus_initiator: a vector table of single
// commands plus hand-written latency, back-pressure and reset-abort sequences.
module tb_tqvp_bus_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        rsp_error;
    logic        busy;
    logic [5:0]  per_address;
    logic [31:0] per_wdata;
    logic [1:0]  per_write_n;
    logic [1:0]  per_read_n;
    logic [31:0] per_rdata;
    logic        per_ready = 1'b0;

    always #5 clk = ~clk;

    tqvp_bus_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .rsp_error(rsp_error),
        .busy(busy), .per_address(per_address), .per_wdata(per_wdata),
        .per_write_n(per_write_n), .per_read_n(per_read_n),
        .per_rdata(per_rdata), .per_ready(per_ready)
    );

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic        timeout;
        logic        error;
    } exp_t;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] prdata;     // responder data_out
        logic        tied;       // data_ready tied high
        int          delay;      // read_n cycles before data_ready
        logic [31:0] exp_rdata;
        logic        exp_to;
        logic        exp_err;
        int          exp_len;    // expected strobe length in cycles
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[9];

    int n_checks = 0;
    int n_pass   = 0;

    // Responder model controls (written by the stimulus thread only)
    logic ready_tied  = 1'b0;
    int   ready_delay = 0;

    // Bus observations (written by the monitor only)
    int          wr_len_cur = 0, wr_done = 0, last_wr_len = 0;
    logic [5:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [1:0]  last_wr_n = 2'b11;
    int          rd_len_cur = 0, rd_done = 0, last_rd_len = 0;
    logic [5:0]  rd_addr0 = '0, last_rd_addr = '0;
    logic        rd_unstable = 1'b0, last_rd_unstable = 1'b0;
    logic [1:0]  last_rd_n = 2'b11;
    int          both_err = 0;

    // Bus monitor and responder: records strobe lengths and raises data_ready.
    always @(negedge clk) begin
        if (per_write_n != 2'b11) begin
            wr_len_cur   <= wr_len_cur + 1;
            last_wr_addr <= per_address;
            last_wr_data <= per_wdata;
            last_wr_n    <= per_write_n;
        end else if (wr_len_cur > 0) begin
            wr_done     <= wr_done + 1;
            last_wr_len <= wr_len_cur;
            wr_len_cur  <= 0;
        end
        if (per_read_n != 2'b11) begin
            if (rd_len_cur == 0) begin
                rd_addr0    <= per_address;
                rd_unstable <= 1'b0;
            end else if (per_address !== rd_addr0) begin
                rd_unstable <= 1'b1;
            end
            rd_len_cur <= rd_len_cur + 1;
            last_rd_n  <= per_read_n;
        end else if (rd_len_cur > 0) begin
            rd_done          <= rd_done + 1;
            last_rd_len      <= rd_len_cur;
            last_rd_addr     <= rd_addr0;
            last_rd_unstable <= rd_unstable;
            rd_len_cur       <= 0;
        end
        if (per_write_n != 2'b11 && per_read_n != 2'b11) both_err <= both_err + 1;
        per_ready <= ready_tied || (per_read_n != 2'b11 && (rd_len_cur + 1) > ready_delay);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one command; the expected response is queued when it is accepted.
    task automatic send(input logic w, input logic [1:0] s, input logic [5:0] a,
                        input logic [31:0] d, input exp_t e);
        bit ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_size  = s;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                exp_q.push_back(e);
            end
            step();
        end
        cmd_valid = 1'b0;
        if (!ok) check("cmd_accept", 32'd0, 32'd1);
    endtask

    task automatic compare_rsp();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("rsp_write",   32'(rsp_write),   32'(e.write));
        check("rsp_rdata",   rsp_rdata,        e.rdata);
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
        check("rsp_error",   32'(rsp_error),   32'(e.error));
    endtask

    // Waits for the next response (rsp_ready must already be high).
    task automatic wait_rsp();
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                compare_rsp();
            end
        end
        if (!got) check("rsp_arrival", 32'd0, 32'd1);
        step();
    endtask

    initial begin
        exp_t e;
        exp_t bp_e[4];
        logic bp_w[4];
        logic [1:0] bp_s[4];
        logic [5:0] bp_a[4];
        logic [31:0] bp_d[4];
        int wr0, rd0, accepted, got, rsp_seen, bus_seen;
        bit found;

        vecs[0] = '{1'b1, 2'b10, 6'h00, 32'hA000_0000, 32'h0,         1'b0, 0,       32'h0000_0000, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 2'b00, 6'h18, 32'h0,         32'h1234_56AB, 1'b1, 0,       32'h0000_00AB, 1'b0, 1'b0, 1};
        vecs[2] = '{1'b0, 2'b01, 6'h05, 32'h0,         32'hCAFE_BEEF, 1'b0, 5,       32'h0000_BEEF, 1'b0, 1'b0, 6};
        vecs[3] = '{1'b0, 2'b10, 6'h3F, 32'h0,         32'h89AB_CDEF, 1'b0, 2,       32'h89AB_CDEF, 1'b0, 1'b0, 3};
        vecs[4] = '{1'b1, 2'b00, 6'h21, 32'h0000_005A, 32'h0,         1'b0, 0,       32'h0000_0000, 1'b0, 1'b0, 1};
        vecs[5] = '{1'b1, 2'b01, 6'h10, 32'hDEAD_1234, 32'h0,         1'b0, 0,       32'h0000_0000, 1'b0, 1'b0, 1};
        vecs[6] = '{1'b0, 2'b00, 6'h2C, 32'h0,         32'h5555_5555, 1'b0, 1000000, 32'hFFFF_FFFF, 1'b1, 1'b0, 16};
        vecs[7] = '{1'b0, 2'b11, 6'h07, 32'h0,         32'h0,         1'b0, 0,       32'h0000_0000, 1'b0, 1'b1, 0};
        vecs[8] = '{1'b1, 2'b11, 6'h08, 32'h1,         32'h0,         1'b0, 0,       32'h0000_0000, 1'b0, 1'b1, 0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1; per_rdata = '0;
        repeat (3) step();

        // Reset state
        @(negedge clk);
        check("rst_write_n",   32'(per_write_n), 32'h3);
        check("rst_read_n",    32'(per_read_n),  32'h3);
        check("rst_address",   32'(per_address), 32'h0);
        check("rst_wdata",     per_wdata,        32'h0);
        check("rst_rsp_valid", 32'(rsp_valid),   32'h0);
        check("rst_rsp_rdata", rsp_rdata,        32'h0);
        check("rst_busy",      32'(busy),        32'h0);
        check("rst_cmd_ready", 32'(cmd_ready),   32'h1);
        step();
        rst = 1'b0;
        step();

        // Issue latency: push at edge k, strobe visible from edge k+2
        e = '{1'b1, 32'h0, 1'b0, 1'b0};
        send(1'b1, 2'b10, 6'h2A, 32'h1357_9BDF, e);
        @(negedge clk);
        check("lat_k_write_n",  32'(per_write_n), 32'h3);
        check("lat_k_busy",     32'(busy),        32'h1);
        @(negedge clk);
        check("lat_k1_write_n", 32'(per_write_n), 32'h3);
        @(negedge clk);
        check("lat_k2_write_n", 32'(per_write_n), 32'h2);
        check("lat_k2_address", 32'(per_address), 32'h2A);
        check("lat_k2_wdata",   per_wdata,        32'h1357_9BDF);
        wait_rsp();

        // Single-command vector table
        for (int i = 0; i < 9; i++) begin
            per_rdata   = vecs[i].prdata;
            ready_tied  = vecs[i].tied;
            ready_delay = vecs[i].delay;
            wr0 = wr_done;
            rd0 = rd_done;
            e = '{vecs[i].write, vecs[i].exp_rdata, vecs[i].exp_to, vecs[i].exp_err};
            send(vecs[i].write, vecs[i].size, vecs[i].addr, vecs[i].wdata, e);
            wait_rsp();
            if (vecs[i].exp_err) begin
                check($sformatf("v%0d_no_write", i), 32'(wr_done - wr0), 32'd0);
                check($sformatf("v%0d_no_read", i),  32'(rd_done - rd0), 32'd0);
            end else if (vecs[i].write) begin
                check($sformatf("v%0d_wr_count", i), 32'(wr_done - wr0), 32'd1);
                check($sformatf("v%0d_wr_len", i),   32'(last_wr_len),   32'(vecs[i].exp_len));
                check($sformatf("v%0d_wr_addr", i),  32'(last_wr_addr),  32'(vecs[i].addr));
                check($sformatf("v%0d_wr_data", i),  last_wr_data,       vecs[i].wdata);
                check($sformatf("v%0d_wr_n", i),     32'(last_wr_n),     32'(vecs[i].size));
            end else begin
                check($sformatf("v%0d_rd_count", i),  32'(rd_done - rd0),    32'd1);
                check($sformatf("v%0d_rd_len", i),    32'(last_rd_len),      32'(vecs[i].exp_len));
                check($sformatf("v%0d_rd_addr", i),   32'(last_rd_addr),     32'(vecs[i].addr));
                check($sformatf("v%0d_rd_n", i),      32'(last_rd_n),        32'(vecs[i].size));
                check($sformatf("v%0d_rd_stable", i), 32'(last_rd_unstable), 32'd0);
            end
            ready_tied = 1'b0;
            step();
        end

        // Back-pressure: responses stalled, four commands offered back to back
        bp_w[0] = 1'b1; bp_s[0] = 2'b10; bp_a[0] = 6'h01; bp_d[0] = 32'h1111_1111;
        bp_w[1] = 1'b0; bp_s[1] = 2'b01; bp_a[1] = 6'h02; bp_d[1] = 32'h0;
        bp_w[2] = 1'b0; bp_s[2] = 2'b11; bp_a[2] = 6'h03; bp_d[2] = 32'h0;
        bp_w[3] = 1'b1; bp_s[3] = 2'b00; bp_a[3] = 6'h04; bp_d[3] = 32'h0000_0044;
        bp_e[0] = '{1'b1, 32'h0000_0000, 1'b0, 1'b0};
        bp_e[1] = '{1'b0, 32'h0000_F00D, 1'b0, 1'b0};
        bp_e[2] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1};
        bp_e[3] = '{1'b1, 32'h0000_0000, 1'b0, 1'b0};
        per_rdata   = 32'h0BAD_F00D;
        ready_delay = 0;
        rsp_ready   = 1'b0;
        wr0 = wr_done;
        rd0 = rd_done;
        accepted = 0;
        cmd_valid = 1'b1;
        cmd_write = bp_w[0]; cmd_size = bp_s[0]; cmd_addr = bp_a[0]; cmd_wdata = bp_d[0];
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(bp_e[accepted]);
                accepted++;
            end
            step();
            if (accepted < 4) begin
                cmd_write = bp_w[accepted]; cmd_size = bp_s[accepted];
                cmd_addr  = bp_a[accepted]; cmd_wdata = bp_d[accepted];
            end else begin
                cmd_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("bp_accepts",   32'(accepted),  32'd3);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_busy",      32'(busy),      32'd1);
        step();
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                compare_rsp();
                got++;
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(bp_e[accepted]);
                accepted++;
            end
            step();
            if (accepted == 4) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        step();
        check("bp_responses", 32'(got),           32'd4);
        check("bp_all_taken", 32'(accepted),      32'd4);
        check("bp_queue_left", 32'(exp_q.size()), 32'd0);
        check("bp_writes",    32'(wr_done - wr0), 32'd2);
        check("bp_reads",     32'(rd_done - rd0), 32'd1);

        // Reset during a read with a write still queued behind it
        ready_delay = 1000000;
        e = '{1'b0, 32'h0, 1'b0, 1'b0};
        send(1'b0, 2'b10, 6'h11, 32'h0, e);
        e = '{1'b1, 32'h0, 1'b0, 1'b0};
        send(1'b1, 2'b00, 6'h12, 32'h0000_0077, e);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (per_read_n != 2'b11) found = 1'b1;
        end
        check("abort_read_started", 32'(found), 32'd1);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("abort_read_n",    32'(per_read_n), 32'h3);
        check("abort_rsp_valid", 32'(rsp_valid),  32'h0);
        check("abort_busy",      32'(busy),       32'h0);
        check("abort_cmd_ready", 32'(cmd_ready),  32'h1);
        step();
        rst = 1'b0;
        exp_q.delete();
        rsp_seen = 0;
        bus_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
            if (per_read_n != 2'b11 || per_write_n != 2'b11) bus_seen++;
            step();
        end
        check("abort_no_rsp", 32'(rsp_seen), 32'd0);
        check("abort_no_bus", 32'(bus_seen), 32'd0);

        check("strobes_exclusive", 32'(both_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
